// File: rtl/instr_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding one network_source through a single registered
// output stage. A producer owns the stream from grant until its last beat is accepted.
module instr_stream_arbiter #(
  parameter int INSTR_WIDTH = 32,
  parameter int NUM_REQ     = 2,
  parameter int ID_WIDTH    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           arst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*INSTR_WIDTH-1:0] req_instr,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           src_valid,
  output logic [INSTR_WIDTH-1:0]         src,
  output logic                           src_last,
  input  logic                           src_ready,
  output logic [ID_WIDTH-1:0]            grant_id,
  output logic                           busy
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]             state;
  logic [ID_WIDTH-1:0]    rr_ptr;
  logic [ID_WIDTH-1:0]    pick_id;
  logic                   pick_vld;
  logic                   out_free;
  logic                   accept_p0;
  logic                   beat_last_p0;
  logic [INSTR_WIDTH-1:0] beat_p0;
  int                     idx;

  function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id);
    if (int'(id) >= NUM_REQ - 1) return '0;
    return id + ID_WIDTH'(1);
  endfunction

  // Round-robin scan starting at rr_ptr; only consulted while IDLE.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = rr_ptr;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!pick_vld && req_valid[idx]) begin
        pick_vld = 1'b1;
        pick_id  = ID_WIDTH'(idx);
      end
    end
  end

  assign out_free     = !src_valid || src_ready;
  assign beat_p0      = req_instr[int'(grant_id)*INSTR_WIDTH +: INSTR_WIDTH];
  assign beat_last_p0 = req_last[grant_id];
  assign accept_p0    = (state == LOCKED) && req_valid[grant_id] && out_free;
  assign busy         = (state == LOCKED);

  always_comb begin
    req_ready = '0;
    if (state == LOCKED) req_ready[grant_id] = out_free;
  end

  // Stage p0 -> output register: accepted beat lands on src one cycle later.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      src_valid <= 1'b0;
      src       <= '0;
      src_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state    <= LOCKED;
            grant_id <= pick_id;
          end
        end
        LOCKED: begin
          if (accept_p0 && beat_last_p0) begin
            state  <= IDLE;
            rr_ptr <= next_id(grant_id);
          end
        end
        default: state <= IDLE;
      endcase

      if (accept_p0) begin
        src_valid <= 1'b1;
        src       <= beat_p0;
        src_last  <= beat_last_p0;
      end else if (src_valid && src_ready) begin
        src_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_stream_arbiter.sv
// Randomized bench for instr_stream_arbiter: producers feed packet queues, a transaction-level
// model predicts ownership, handshakes and the output beat stream cycle by cycle.
module tb_instr_stream_arbiter;

  localparam int W   = 32;
  localparam int N   = 2;
  localparam int IDW = 1;

  typedef logic [W:0] beat_t;  // {last, data}

  logic           clk = 1'b0;
  logic           arst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_instr = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           src_valid;
  logic [W-1:0]   src;
  logic           src_last;
  logic           src_ready = 1'b0;
  logic [IDW-1:0] grant_id;
  logic           busy;

  instr_stream_arbiter #(.INSTR_WIDTH(W), .NUM_REQ(N), .ID_WIDTH(IDW)) dut (
    .clk(clk), .arst(arst), .req_valid(req_valid), .req_instr(req_instr),
    .req_last(req_last), .req_ready(req_ready), .src_valid(src_valid), .src(src),
    .src_last(src_last), .src_ready(src_ready), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // producer side
  beat_t pq[N][$];
  bit    pres[N];
  int    pres_pct = 100;

  // reference model state
  int           m_owner = -1;
  int           m_ptr   = 0;
  int           m_gid   = 0;
  bit           m_ov    = 1'b0;
  logic [W-1:0] m_od    = '0;
  bit           m_ol    = 1'b0;
  beat_t        exp_q[$];
  logic [W-1:0] xfer_log[$];
  int           xfer_cyc[$];
  int           grant_log[$];
  bit           prev_busy = 1'b0;

  task automatic drive_producers();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pres[i];
      if (pres[i]) begin
        req_instr[i*W +: W] = pq[i][0][W-1:0];
        req_last[i]         = pq[i][0][W];
      end else begin
        req_instr[i*W +: W] = $urandom;
        req_last[i]         = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++)
      if (!pres[i] && pq[i].size() > 0 && $urandom_range(0, 99) < pres_pct) pres[i] = 1'b1;
    drive_producers();
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_gid = 0; m_ov = 1'b0; m_od = '0; m_ol = 1'b0;
    prev_busy = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      pres[i] = 1'b0;
    end
    drive_producers();
  endtask

  task automatic do_reset();
    arst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
  endtask

  task automatic push_pkt(input int p, input int len, input logic [W-1:0] base);
    for (int b = 0; b < len; b++) pq[p].push_back({(b == len - 1), base + W'(b)});
  endtask

  function automatic bit drained();
    for (int i = 0; i < N; i++) if (pq[i].size() != 0) return 1'b0;
    return exp_q.size() == 0 && !m_ov && m_owner < 0;
  endfunction

  function automatic int seq_code(input int q[$]);
    int c = 1;
    foreach (q[k]) c = c * 2 + q[k];
    return c;
  endfunction

  // One clock: compare against the model at negedge, advance the model at posedge.
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    bit rdy, acc;
    int sel;
    beat_t e, b;
    @(negedge clk);
    cyc++;
    rdy = src_ready;
    exp_rdy = '0;
    if (m_owner >= 0 && (!m_ov || rdy)) exp_rdy[m_owner] = 1'b1;
    total++;
    if ({src_valid, src, src_last, busy, grant_id, req_ready} !==
        {m_ov, m_od, m_ol, (m_owner >= 0), IDW'(m_gid), exp_rdy}) begin
      bad++;
      $display("FAIL outputs cyc=%0d: got v=%b src=%h last=%b busy=%b gid=%0d rdy=%b, want v=%b src=%h last=%b busy=%b gid=%0d rdy=%b",
               cyc, src_valid, src, src_last, busy, grant_id, req_ready,
               m_ov, m_od, m_ol, (m_owner >= 0), m_gid, exp_rdy);
    end
    if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
    prev_busy = busy;
    if (src_valid && src_ready) begin
      xfer_log.push_back(src);
      xfer_cyc.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard cyc=%0d: got unexpected beat %h, want none", cyc, src);
      end else begin
        e = exp_q.pop_front();
        if ({src_last, src} !== e) begin
          bad++;
          $display("FAIL scoreboard cyc=%0d: got last=%b %h, want last=%b %h",
                   cyc, src_last, src, e[W], e[W-1:0]);
        end
      end
    end
    acc = 1'b0;
    sel = -1;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++)
        if (sel < 0 && req_valid[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
    end else begin
      acc = req_valid[m_owner] && (!m_ov || rdy);
    end
    @(posedge clk);
    #1;
    if (!acc && m_ov && rdy) m_ov = 1'b0;
    if (sel >= 0) begin
      m_owner = sel;
      m_gid   = sel;
    end else if (acc) begin
      b = pq[m_owner].pop_front();
      pres[m_owner] = 1'b0;
      exp_q.push_back(b);
      m_ov = 1'b1; m_od = b[W-1:0]; m_ol = b[W];
      if (b[W]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
    refresh();
  endtask

  task automatic run(input int max_cyc, input int rdy_pct);
    int n = 0;
    while (!drained() && n < max_cyc) begin
      src_ready = ($urandom_range(0, 99) < rdy_pct);
      cycle();
      n++;
    end
    total++;
    if (!drained()) begin
      bad++;
      $display("FAIL drain: got pending beats after %0d cycles, want all delivered", max_cyc);
    end
  endtask

  task automatic test_reset();
    do_reset();
    src_ready = 1'b1;
    cycle();
    push_pkt(0, 4, 32'h50);
    refresh();
    repeat (3) cycle();
    total++;
    if (src_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_setup: got src_valid=%b, want 1", src_valid);
    end
    #2 arst = 1'b1;
    #1;
    total++;
    if ({src_valid, src, src_last, req_ready, busy, grant_id} !== '0) begin
      bad++;
      $display("FAIL reset_async: got v=%b src=%h last=%b rdy=%b busy=%b gid=%0d, want all 0",
               src_valid, src, src_last, req_ready, busy, grant_id);
    end
    model_reset();
    @(posedge clk);
    #1 arst = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic test_single();
    logic [W-1:0] want[4];
    int errs = 0;
    want[0] = 32'hA; want[1] = 32'hB; want[2] = 32'hC; want[3] = 32'hD;
    do_reset();
    pres_pct = 100;
    for (int k = 0; k < 4; k++) pq[0].push_back({(k == 3), want[k]});
    xfer_log.delete();
    xfer_cyc.delete();
    refresh();
    run(50, 100);
    if (xfer_log.size() != 4) errs++;
    else for (int k = 0; k < 4; k++) if (xfer_log[k] !== want[k]) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL single_seq: got %0d beats (%0d wrong), want A,B,C,D", xfer_log.size(), errs);
    end
    total++;
    if (xfer_cyc.size() != 4 || xfer_cyc[3] - xfer_cyc[0] != 3) begin
      bad++;
      $display("FAIL single_rate: got %0d beats not on 4 consecutive cycles, want consecutive",
               xfer_cyc.size());
    end
  endtask

  task automatic test_contention();
    do_reset();
    pres_pct = 100;
    grant_log.delete();
    push_pkt(0, 3, 32'h100);
    push_pkt(1, 3, 32'h200);
    refresh();
    run(100, 100);
    total++;
    if (seq_code(grant_log) != 5) begin
      bad++;
      $display("FAIL contention_order: got code %0d (%0d grants), want 5 (0,1)",
               seq_code(grant_log), grant_log.size());
    end
    push_pkt(1, 3, 32'h210);
    push_pkt(0, 3, 32'h110);
    refresh();
    run(100, 100);
    total++;
    if (seq_code(grant_log) != 21) begin
      bad++;
      $display("FAIL contention_wrap: got code %0d (%0d grants), want 21 (0,1,0,1)",
               seq_code(grant_log), grant_log.size());
    end
  endtask

  task automatic test_fairness();
    int want = 1;
    do_reset();
    pres_pct = 100;
    grant_log.delete();
    for (int k = 0; k < 4; k++) begin
      push_pkt(0, 2, 32'h300 + W'(k * 16));
      push_pkt(1, 2, 32'h400 + W'(k * 16));
    end
    for (int k = 0; k < 8; k++) want = want * 2 + (k % 2);
    refresh();
    run(200, 100);
    total++;
    if (seq_code(grant_log) != want) begin
      bad++;
      $display("FAIL fairness: got code %0d (%0d grants), want %0d (alternating)",
               seq_code(grant_log), grant_log.size(), want);
    end
  endtask

  task automatic test_backpressure();
    int errs = 0;
    do_reset();
    pres_pct = 100;
    push_pkt(0, 8, 32'h500);
    xfer_log.delete();
    refresh();
    src_ready = 1'b1;
    repeat (4) cycle();
    src_ready = 1'b0;
    repeat (5) cycle();
    run(100, 100);
    if (xfer_log.size() != 8) errs++;
    else for (int k = 0; k < 8; k++) if (xfer_log[k] !== 32'h500 + W'(k)) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL backpressure_seq: got %0d beats (%0d wrong), want 8 in order",
               xfer_log.size(), errs);
    end
  endtask

  task automatic test_random_bubbles();
    int beats = 0;
    int len;
    do_reset();
    pres_pct = 60;
    xfer_log.delete();
    for (int k = 0; k < 20; k++) begin
      push_pkt(1, 1, 32'h1000 + W'(k));
      beats++;
    end
    for (int k = 0; k < 8; k++) begin
      len = $urandom_range(1, 4);
      push_pkt(0, len, 32'h2000 + W'(k * 16));
      beats += len;
    end
    refresh();
    run(3000, 70);
    total++;
    if (xfer_log.size() != beats) begin
      bad++;
      $display("FAIL random_count: got %0d beats, want %0d", xfer_log.size(), beats);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_random_bubbles();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
